// File: rtl/ieee_div_round_pack_if.sv
// Handshake bus for the divider round/pack stage: operand side and result side.
// The slave modport is the stage's view; the master modport drives it.
interface ieee_div_round_pack_if;
   logic        in_valid;
   logic        in_ready;
   logic        in_sign;
   logic [9:0]  in_exp;
   logic [25:0] in_quot;
   logic        in_rem_nz;
   logic [1:0]  in_special;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_result;
   logic [2:0]  out_flags;

   modport slave (
      input  in_valid, in_sign, in_exp, in_quot, in_rem_nz, in_special, out_ready,
      output in_ready, out_valid, out_result, out_flags
   );

   modport master (
      output in_valid, in_sign, in_exp, in_quot, in_rem_nz, in_special, out_ready,
      input  in_ready, out_valid, out_result, out_flags
   );
endinterface

// File: rtl/ieee_div_round_pack.sv
// IEEE-754 single divider back end: stage 1 normalises the raw quotient,
// stage 2 rounds to nearest-even, detects overflow/underflow and packs the result.
module ieee_div_round_pack #(
   parameter logic [31:0] QNAN         = 32'h7FC0_0000,
   parameter bit          FLUSH_DENORM = 1'b1
) (
   input  logic                  clk,
   input  logic                  rstn,
   ieee_div_round_pack_if.slave  bus
);

   logic               s1_valid_q;
   logic [22:0]        s1_mant_q,   s1_mant_d;
   logic               s1_guard_q,  s1_guard_d;
   logic               s1_sticky_q, s1_sticky_d;
   logic signed [9:0]  s1_e_q,      s1_e_d;
   logic               s1_sign_q;
   logic [1:0]         s1_special_q;

   logic               s2_valid_q;
   logic [31:0]        s2_result_q, s2_result_d;
   logic [2:0]         s2_flags_q,  s2_flags_d;

   logic               s1_adv;
   logic               inc;
   logic               carry;
   logic [22:0]        frac;
   logic signed [9:0]  e_r;
   logic               inexact;

   assign s1_adv       = !s2_valid_q | bus.out_ready;
   assign bus.in_ready = !s1_valid_q | s1_adv;

   assign bus.out_valid  = s2_valid_q;
   assign bus.out_result = s2_result_q;
   assign bus.out_flags  = s2_flags_q;

   // Quotient lies in (0.5, 2): at most a one-bit left shift is ever needed.
   always_comb begin
      if (bus.in_quot[25]) begin
         s1_mant_d   = bus.in_quot[24:2];
         s1_guard_d  = bus.in_quot[1];
         s1_sticky_d = bus.in_quot[0] | bus.in_rem_nz;
         s1_e_d      = $signed(bus.in_exp);
      end else begin
         s1_mant_d   = bus.in_quot[23:1];
         s1_guard_d  = bus.in_quot[0];
         s1_sticky_d = bus.in_rem_nz;
         s1_e_d      = $signed(bus.in_exp) - 10'sd1;
      end
   end

   // The hidden one is left out of the add: a carry out of the 23-bit fraction
   // is exactly the mantissa overflow case, and it leaves the fraction at zero.
   always_comb begin
      inc           = s1_guard_q & (s1_sticky_q | s1_mant_q[0]);
      {carry, frac} = {1'b0, s1_mant_q} + {23'd0, inc};
      e_r           = carry ? s1_e_q + 10'sd1 : s1_e_q;
      inexact       = s1_guard_q | s1_sticky_q;
      s2_result_d   = {s1_sign_q, e_r[7:0], frac};
      s2_flags_d    = {2'b00, inexact};
      if (e_r >= 10'sd255) begin
         s2_result_d = {s1_sign_q, 8'hFF, 23'h0};
         s2_flags_d  = {1'b1, 1'b0, inexact};
      end else if (FLUSH_DENORM && (e_r <= 10'sd0)) begin
         s2_result_d = {s1_sign_q, 31'h0};
         s2_flags_d  = {1'b0, 1'b1, inexact};
      end
      case (s1_special_q)
         2'b01: begin
            s2_result_d = {s1_sign_q, 31'h0};
            s2_flags_d  = '0;
         end
         2'b10: begin
            s2_result_d = {s1_sign_q, 8'hFF, 23'h0};
            s2_flags_d  = '0;
         end
         2'b11: begin
            s2_result_d = QNAN;
            s2_flags_d  = '0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         s1_valid_q   <= 1'b0;
         s1_mant_q    <= '0;
         s1_guard_q   <= 1'b0;
         s1_sticky_q  <= 1'b0;
         s1_e_q       <= '0;
         s1_sign_q    <= 1'b0;
         s1_special_q <= '0;
         s2_valid_q   <= 1'b0;
         s2_result_q  <= '0;
         s2_flags_q   <= '0;
      end else begin
         if (bus.in_ready) begin
            s1_valid_q <= bus.in_valid;
            if (bus.in_valid) begin
               s1_mant_q    <= s1_mant_d;
               s1_guard_q   <= s1_guard_d;
               s1_sticky_q  <= s1_sticky_d;
               s1_e_q       <= s1_e_d;
               s1_sign_q    <= bus.in_sign;
               s1_special_q <= bus.in_special;
            end
         end
         if (s1_adv) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
               s2_result_q <= s2_result_d;
               s2_flags_q  <= s2_flags_d;
            end
         end
      end
   end

endmodule

// File: doc/ieee_div_round_pack.md
Name: ieee_div_round_pack

Overview:
- Downstream stage of the IEEE single-precision divider.
- Consumes the raw mantissa quotient, pre-normalisation exponent, sign, remainder-nonzero flag and special-case code produced by the divider.
- Normalises, rounds to nearest-even, detects overflow/underflow and packs a 32-bit IEEE-754 result.
- Two-stage pipeline with valid/ready handshake on both sides.

Parameters:
- QNAN, 32'h7FC0_0000: bit pattern emitted for the NaN special case.
- FLUSH_DENORM, 1: results with exponent <= 0 flush to signed zero. Only value 1 is supported; there is no subnormal output.

Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream operand valid.
- in_ready  out  1  stage accepts operand this cycle.
- in_sign  in  1  result sign (num1 sign XOR num2 sign).
- in_exp  in  10  signed two's-complement biased exponent, e1 - e2 + 127, before normalisation.
- in_quot  in  26  quotient in Q1.25; value = in_quot / 2^25, range (0.5, 2).
- in_rem_nz  in  1  divider remainder nonzero; feeds sticky.
- in_special  in  2  00 normal, 01 zero, 10 infinity, 11 NaN.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_result  out  32  packed IEEE-754 single.
- out_flags  out  3  {overflow, underflow, inexact}.

Behaviour:
- Reset (rstn low, asynchronous): both stage valid bits clear; out_valid=0, out_result=0, out_flags=0, in_ready=1 after reset.
- Transfers:
  - Input transfer occurs on in_valid & in_ready.
  - Output transfer occurs on out_valid & out_ready.
  - out_result and out_flags hold stable while out_valid=1 and out_ready=0.
- Stage advance: a stage loads when it is empty or its contents move on in the same cycle.
  - in_ready = !s1_valid | s1_adv, where s1_adv = !s2_valid | out_ready. Combinational ready path is allowed.
- Latency: 2 cycles from input transfer to out_valid with no stall. Throughput is 1 per cycle. In-order, no drops, no duplicates.
- Stage 1 (normalise):
  - If in_quot[25]=1: mant = in_quot[24:2], guard = in_quot[1], sticky = in_quot[0] | in_rem_nz, e = in_exp.
  - Else: mant = in_quot[23:1], guard = in_quot[0], sticky = in_rem_nz, e = in_exp - 1. in_quot[24]=1 is guaranteed upstream; no further shift.
  - Register mant, guard, sticky, e, sign and special.
- Stage 2 (round and pack):
  - inc = guard & (sticky | mant[0]). sum = {1'b1, mant} + inc (25-bit).
  - On carry (sum[24]): fraction = 0, e_r = e + 1. Otherwise fraction = sum[22:0], e_r = e.
  - inexact = guard | sticky.
  - e_r >= 255: result {sign, 8'hFF, 23'h0}; flags = overflow | inexact.
  - e_r <= 0: result {sign, 31'h0}; flags = underflow | inexact.
  - Otherwise: {sign, e_r[7:0], fraction}.
- Special codes override the arithmetic path and set flags = 0:
  - 01 gives {sign, 31'h0}.
  - 10 gives {sign, 8'hFF, 23'h0}.
  - 11 gives QNAN, with the sign ignored.
- Exponent arithmetic is 10-bit signed throughout; no wrap within the input range -254..381.
- Reset mid-operation: all in-flight results are discarded and are not emitted after reset releases.
- Simultaneous output transfer and input transfer with a full pipeline: both stages shift and the new operand is taken the same cycle.

Test Plan:
- One operand, in_sign=0, in_exp=127, in_quot=26'h2000000, rem_nz=0 -> 2 cycles later out_result=32'h3F800000, flags=000.
- Normalise: in_exp=127, in_quot=26'h1000000 -> 32'h3F000000. Ties: in_quot=26'h2000002 -> 32'h3F800000 (round down to even), flags=001. in_quot=26'h2000006 -> 32'h3F800002, flags=001.
- Round carry: in_exp=127, in_quot=26'h3FFFFFE -> 32'h40000000, inexact. Same operand with in_exp=254 -> 32'h7F800000, flags=101.
- Underflow/specials: in_exp=0, in_quot=26'h2000000, sign=1 -> 32'h80000000, flags=010. Special=11 -> 32'h7FC00000. Special=10 with sign=1 -> 32'hFF800000, flags=000.
- Backpressure: out_ready=0 for 6 cycles while 4 operands are offered -> exactly 2 accepted, in_ready=0 afterwards, out_result stable. Then out_ready=1 -> all 4 results emitted in order, one per cycle, none lost.
- Reset: assert rstn=0 with 2 results in flight -> out_valid=0 immediately (asynchronously). After release no stale result is emitted and in_ready=1.
